// File: rtl/mem_io_responder.sv
// Memory-side responder for the 8-bit CPU bus: 240-byte RAM plus memory-mapped I/O (port, input sync, timer, TX FIFO).
// Optional timer block is built only when MEM_IO_TIMER_EN is defined.
module mem_io_responder #(
  parameter int unsigned PRESCALE   = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic       rden,
  input  logic       wren,
  output logic [7:0] data_out,
  input  logic [7:0] in_port,
  output logic [7:0] out_port,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       irq
);

  localparam int unsigned RAM_WORDS = 240;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;

  localparam logic [7:0] A_OUT    = 8'hF0;
  localparam logic [7:0] A_IN     = 8'hF1;
  localparam logic [7:0] A_TCNT   = 8'hF2;
  localparam logic [7:0] A_TCMP   = 8'hF3;
  localparam logic [7:0] A_STATUS = 8'hF4;
  localparam logic [7:0] A_TXD    = 8'hF5;

  logic [7:0] ram [RAM_WORDS];
  logic [7:0] sync1, sync2;
  logic [7:0] rd_data_c;
  logic       is_ram_c;
  logic       stat_wr_c;
  logic [7:0] tcnt_rd_c, tcmp_rd_c;
  logic       match_rd_c;

  assign is_ram_c  = addr < A_OUT;
  assign stat_wr_c = wren && (addr == A_STATUS);

  // RAM contents survive reset; writes are blocked while rst is high
  always_ff @(posedge clk) begin
    if (!rst && wren && is_ram_c) begin
      ram[addr] <= data_in;
    end
  end

  // Output port latch and two-flop input synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_port <= 8'h00;
      sync1    <= 8'h00;
      sync2    <= 8'h00;
    end else begin
      if (wren && (addr == A_OUT)) begin
        out_port <= data_in;
      end
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             empty_c, full_c, push_c, pop_c, accept_c;

  assign empty_c  = (count == '0);
  assign full_c   = (count == CNT_W'(FIFO_DEPTH));
  assign pop_c    = !empty_c && tx_ready;
  assign push_c   = wren && (addr == A_TXD);
  // A full FIFO still takes a push when a pop frees a slot in the same cycle
  assign accept_c = push_c && (!full_c || pop_c);

  assign tx_valid = !empty_c;
  assign tx_data  = empty_c ? 8'h00 : fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && accept_c) begin
      fifo_mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (accept_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      case ({accept_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push_c && !accept_c) begin
        ovf <= 1'b1;
      end else if (stat_wr_c && data_in[3]) begin
        ovf <= 1'b0;
      end
    end
  end

  // ---------------- Timer ----------------
`ifdef MEM_IO_TIMER_EN
  localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

  logic [7:0] presc, tcnt, tcmp;
  logic [7:0] tcnt_nxt_c;
  logic       match;
  logic       tick_c, tcnt_wr_c, tcmp_wr_c;

  assign tick_c     = (presc == PS_LAST);
  assign tcnt_nxt_c = tcnt + 8'd1;
  assign tcnt_wr_c  = wren && (addr == A_TCNT);
  assign tcmp_wr_c  = wren && (addr == A_TCMP);

  // A TCNT write beats a tick; a match set beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= 8'h00;
      tcnt  <= 8'h00;
      tcmp  <= 8'hFF;
      match <= 1'b0;
    end else begin
      if (tcnt_wr_c) begin
        presc <= 8'h00;
        tcnt  <= 8'h00;
      end else if (tick_c) begin
        presc <= 8'h00;
        tcnt  <= tcnt_nxt_c;
      end else begin
        presc <= presc + 8'd1;
      end
      if (tcmp_wr_c) begin
        tcmp <= data_in;
      end
      if (tick_c && !tcnt_wr_c && (tcnt_nxt_c == tcmp)) begin
        match <= 1'b1;
      end else if (stat_wr_c && data_in[2]) begin
        match <= 1'b0;
      end
    end
  end

  assign irq        = match;
  assign tcnt_rd_c  = tcnt;
  assign tcmp_rd_c  = tcmp;
  assign match_rd_c = match;
`else
  assign irq        = 1'b0;
  assign tcnt_rd_c  = 8'h00;
  assign tcmp_rd_c  = 8'h00;
  assign match_rd_c = 1'b0;
`endif

  // Side-effect-free read mux
  always_comb begin
    rd_data_c = 8'h00;
    if (is_ram_c) begin
      rd_data_c = ram[addr];
    end else begin
      case (addr)
        A_OUT:    rd_data_c = out_port;
        A_IN:     rd_data_c = sync2;
        A_TCNT:   rd_data_c = tcnt_rd_c;
        A_TCMP:   rd_data_c = tcmp_rd_c;
        A_STATUS: rd_data_c = {4'b0000, ovf, match_rd_c, full_c, empty_c};
        A_TXD:    rd_data_c = 8'(count);
        default:  rd_data_c = 8'h00;
      endcase
    end
  end

  // Registered read data; a simultaneous write suppresses the read
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= 8'h00;
    end else if (rden && !wren) begin
      data_out <= rd_data_c;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: behavioural model compared every cycle plus literal spot checks.
module tb_mem_io_responder;

  localparam int unsigned PS    = 2;
  localparam int unsigned DEPTH = 4;
`ifdef MEM_IO_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr, data_in, in_port;
  logic       rden, wren, tx_ready;
  logic [7:0] data_out, out_port, tx_data;
  logic       tx_valid, irq;

  mem_io_responder #(.PRESCALE(PS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rden(rden), .wren(wren),
    .data_out(data_out), .in_port(in_port), .out_port(out_port), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: timer value is derived from cycles elapsed since the last clear
  logic [7:0] ram_m [0:239];
  logic [7:0] m_q [$];
  logic [7:0] m_dout = 8'h00, m_out = 8'h00, m_tcmp = 8'hFF, m_s1 = 8'h00, m_s2 = 8'h00, m_rv;
  logic       m_match = 1'b0, m_ovf = 1'b0, m_set;
  int         m_n = 0;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a < 8'hF0) return ram_m[a];
    case (a)
      8'hF0: return m_out;
      8'hF1: return m_s2;
      8'hF2: return TIMER_EN ? 8'((m_n / PS) % 256) : 8'h00;
      8'hF3: return TIMER_EN ? m_tcmp : 8'h00;
      8'hF4: return {4'b0000, m_ovf, m_match, m_q.size() == DEPTH, m_q.size() == 0};
      8'hF5: return 8'(m_q.size());
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    m_rv = m_read(addr);
    if (rst) begin
      m_dout = 8'h00; m_out = 8'h00; m_tcmp = 8'hFF; m_n = 0;
      m_match = 1'b0; m_ovf = 1'b0; m_s1 = 8'h00; m_s2 = 8'h00;
      m_q.delete();
    end else begin
      if (rden && !wren) m_dout = m_rv;
      if (m_q.size() > 0 && tx_ready) void'(m_q.pop_front());
      m_set = 1'b0;
      if (wren && addr == 8'hF2) m_n = 0;
      else begin
        m_n++;
        m_set = TIMER_EN && (m_n % PS == 0) && (8'((m_n / PS) % 256) == m_tcmp);
      end
      if (wren) begin
        if (addr < 8'hF0) ram_m[addr] = data_in;
        case (addr)
          8'hF0: m_out = data_in;
          8'hF3: m_tcmp = data_in;
          8'hF4: begin
            if (data_in[3]) m_ovf = 1'b0;
            if (data_in[2]) m_match = 1'b0;
          end
          8'hF5: if (m_q.size() < DEPTH) m_q.push_back(data_in); else m_ovf = 1'b1;
          default: ;
        endcase
      end
      if (m_set) m_match = 1'b1;
      m_s2 = m_s1;
      m_s1 = in_port;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and compare all outputs against the model at the falling edge
  task automatic cycle();
    @(negedge clk);
    chk("data_out", data_out, m_dout);
    chk("out_port", out_port, m_out);
    chk("tx_valid", 8'(tx_valid), 8'(m_q.size() > 0));
    chk("tx_data", tx_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
    chk("irq", 8'(irq), 8'(m_match));
  endtask

  task automatic idle();
    rden = 1'b0; wren = 1'b0;
    cycle();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; data_in = d; rden = 1'b0; wren = 1'b1;
    cycle();
    wren = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    addr = a; rden = 1'b1; wren = 1'b0;
    cycle();
    rden = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = 8'h00; data_in = 8'h00; in_port = 8'h00;
    rden = 1'b0; wren = 1'b0; tx_ready = 1'b0;
    cycle(); cycle();
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_out_port", out_port, 8'h00);
    chk("rst_tx_valid", 8'(tx_valid), 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_irq", 8'(irq), 8'h00);
    rst = 1'b0;

    // RAM
    wr(8'h10, 8'h5A); rd(8'h10);
    chk("ram_10", data_out, 8'h5A);
    wr(8'hEF, 8'hC3); rd(8'hEF);
    chk("ram_ef", data_out, 8'hC3);
    rd(8'h10);
    addr = 8'h20; data_in = 8'h11; rden = 1'b1; wren = 1'b1;
    cycle();
    rden = 1'b0; wren = 1'b0;
    chk("both_strobes_hold", data_out, 8'h5A);
    rd(8'h20);
    chk("both_strobes_write", data_out, 8'h11);
    rd(8'hF8);
    chk("unmapped_read", data_out, 8'h00);

    // IN / OUT
    in_port = 8'h3C;
    idle(); idle(); rd(8'hF1);
    chk("in_port_sync", data_out, 8'h3C);
    wr(8'hF0, 8'h81);
    chk("out_port_write", out_port, 8'h81);
    rd(8'hF0);
    chk("out_readback", data_out, 8'h81);

`ifdef MEM_IO_TIMER_EN
    // Timer with PRESCALE=2
    wr(8'hF3, 8'h03); wr(8'hF2, 8'h00);
    repeat (6) idle();
    chk("tmr_irq_set", 8'(irq), 8'h01);
    rd(8'hF2);
    chk("tmr_tcnt3", data_out, 8'h03);
    rd(8'hF4);
    chk("tmr_status", data_out, 8'h05);
    wr(8'hF4, 8'h04);
    chk("tmr_irq_clr", 8'(irq), 8'h00);
    wr(8'hF2, 8'h00); rd(8'hF2);
    chk("tmr_clear", data_out, 8'h00);
    wr(8'hF2, 8'h00);
    repeat (5) idle();
    wr(8'hF4, 8'h04);
    chk("tmr_set_wins", 8'(irq), 8'h01);
    wr(8'hF4, 8'h04);
    wr(8'hF2, 8'h00); idle(); wr(8'hF2, 8'h00); rd(8'hF2);
    chk("tmr_write_wins", data_out, 8'h00);
    wr(8'hF3, 8'h00); wr(8'hF2, 8'h00);
    repeat (511) idle();
    chk("tmr_wrap_pre", 8'(irq), 8'h00);
    idle();
    chk("tmr_wrap_irq", 8'(irq), 8'h01);
    rd(8'hF2);
    chk("tmr_wrap_zero", data_out, 8'h00);
    wr(8'hF4, 8'h04); wr(8'hF3, 8'hFF);
`else
    wr(8'hF3, 8'h42); rd(8'hF3);
    chk("no_tmr_tcmp", data_out, 8'h00);
    rd(8'hF2);
    chk("no_tmr_tcnt", data_out, 8'h00);
`endif

    // FIFO overflow and drain
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'hF5, 8'(8'hA0 + i));
    rd(8'hF5);
    chk("fifo_count4", data_out, 8'h04);
    rd(8'hF4);
    chk("fifo_full_ovf", data_out & 8'h0B, 8'h0A);
    chk("fifo_head", tx_data, 8'hA0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fifo_order", tx_data, 8'(8'hA0 + i));
      idle();
    end
    tx_ready = 1'b0;
    chk("fifo_drained", 8'(tx_valid), 8'h00);
    rd(8'hF4);
    chk("fifo_empty_ovf", data_out & 8'h0B, 8'h09);
    wr(8'hF4, 8'h08); rd(8'hF4);
    chk("fifo_ovf_clr", data_out & 8'h0B, 8'h01);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) wr(8'hF5, 8'(8'hB0 + i));
    tx_ready = 1'b1;
    wr(8'hF5, 8'hB4);
    tx_ready = 1'b0;
    rd(8'hF4);
    chk("fifo_pushpop_full", data_out & 8'h0B, 8'h02);
    rd(8'hF5);
    chk("fifo_pushpop_cnt", data_out, 8'h04);
    chk("fifo_pushpop_head", tx_data, 8'hB1);

    // Reset mid-operation
`ifdef MEM_IO_TIMER_EN
    wr(8'hF2, 8'h00);
    repeat (254) idle();
    rd(8'hF2);
    chk("pre_rst_tcnt", data_out, 8'h7F);
`endif
    rst = 1'b1; addr = 8'h10; data_in = 8'hEE; wren = 1'b1; rden = 1'b0;
    cycle();
    rst = 1'b0; wren = 1'b0;
    chk("mid_rst_tx_valid", 8'(tx_valid), 8'h00);
    chk("mid_rst_data_out", data_out, 8'h00);
    chk("mid_rst_out_port", out_port, 8'h00);
    rd(8'hF2);
    chk("mid_rst_tcnt", data_out, 8'h00);
    rd(8'hF3);
    chk("mid_rst_tcmp", data_out, TIMER_EN ? 8'hFF : 8'h00);
    rd(8'h10);
    chk("mid_rst_ram", data_out, 8'h5A);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the 8-bit CPU's single-port bus (addr, data_in, rden, wren, data_out). It decodes each access into a 240-byte RAM array or a block of memory-mapped I/O registers. The I/O block holds an output port, a synchronized input port, a prescaled timer with compare flag, and a transmit FIFO drained by an external valid/ready sink. It replaces the bare RAM instance next to the CPU and gives programs LD/ST access to peripherals.

## Interface
Parameters:
- PRESCALE, 16: clock cycles per timer tick; legal range 1–255.
- FIFO_DEPTH, 4: TX FIFO entries; must be a power of two, 2–16.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- addr  in  8  CPU byte address.
- data_in  in  8  write data, CPU to memory.
- rden  in  1  read strobe.
- wren  in  1  write strobe.
- data_out  out  8  registered read data, memory to CPU.
- in_port  in  8  asynchronous external input pins.
- out_port  out  8  output port latch.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  sink accepts tx_data when it is high together with tx_valid.
- irq  out  1  level copy of the sticky timer-match flag.

## Operation
Address map:
- 0x00–0xEF: RAM. Read/write. Contents are not cleared by rst.
- 0xF0 OUT: read/write; value drives out_port.
- 0xF1 IN: read-only; returns in_port after a 2-flop synchronizer.
- 0xF2 TCNT: a read returns the timer. A write of any value clears both the timer and the prescaler.
- 0xF3 TCMP: read/write compare value.
- 0xF4 STATUS: read returns {4'b0, ovf, match, full, empty}. Writing 1 to bit2 clears match; writing 1 to bit3 clears ovf.
- 0xF5 TXD: a write pushes data_in into the FIFO. A read returns the FIFO count, zero-extended.
- 0xF6–0xFF: read 0; writes are ignored.

Bus rules:
- The read path performs no side effects, including reads of TXD and STATUS.
- When rden and wren are high together, the write is performed, the read is ignored, and data_out holds.

Timer:
- The prescaler counts 0..PRESCALE-1.
- At the terminal count the prescaler wraps to 0 and TCNT increments modulo 256 (0xFF wraps to 0x00).
- When the incremented value equals TCMP, the match flag sets.
- If a TCNT write and a tick fall in the same cycle, the write wins.
- If a match set and a match-clear write fall in the same cycle, the set wins.

FIFO:
- Circular buffer with count width clog2(FIFO_DEPTH)+1.
- A pop happens on tx_valid && tx_ready.
- A push when full is dropped and sets ovf.
- A push and a pop in the same cycle both occur; count is unchanged.
- A push into an empty FIFO becomes visible one cycle later; there is no fall-through.
- A full FIFO with simultaneous push and pop accepts the push, and ovf is not set.

## Timing
Reset values:
- data_out 0x00, out_port 0x00, TCNT 0x00, TCMP 0xFF, prescaler 0.
- match 0, ovf 0, FIFO empty (tx_valid 0, tx_data 0x00), irq 0, synchronizer flops 0.

Latency:
- Read: rden sampled at edge N; data_out is valid after edge N and holds until the next accepted read.
- Write: takes effect at the sampling edge. A read of the same address on the next cycle returns the new value.
- in_port to the IN register: 2 cycles; readable on the third cycle.
- irq follows match at the same edge.

rst mid-operation:
- All registers return to their reset values at that edge.
- A read or write strobed in the same cycle as rst is discarded.
- RAM writes are blocked while rst is high.

## Configuration
- MEM_IO_TIMER_EN defined: timer, TCNT, TCMP, match and irq are built as described above.
- MEM_IO_TIMER_EN undefined: no timer logic is built.
  - 0xF2 and 0xF3 read 0x00 and ignore writes.
  - STATUS bit2 reads 0, and writes to it are ignored.
  - irq is tied to 0.

## Test plan
- RAM: write 0x5A to 0x10, then read 0x10 → data_out = 0x5A one cycle after the rden edge. Read 0xEF after writing 0xC3 → 0xC3.
- Simultaneous strobes: rden and wren both high at 0x20 with data_in 0x11 → RAM[0x20] = 0x11 and data_out unchanged from its prior value.
- IN/OUT: in_port = 0x3C, then read 0xF1 on cycle 3 → 0x3C. Write 0x81 to 0xF0 → out_port = 0x81 on the next cycle.
- Timer (PRESCALE=2, TCMP=3): after 6 cycles TCNT = 3, match = 1 and irq = 1. Write 0x04 to 0xF4 → irq = 0. Write to 0xF2 → TCNT = 0.
- FIFO, tx_ready=0: push 0xA0–0xA4 (five pushes) → count = 4, full = 1, ovf = 1, tx_data = 0xA0. Then raise tx_ready for 4 cycles → bytes leave in order A0..A3 and empty = 1.
- Reset mid-operation: assert rst while the FIFO is non-empty and TCNT = 0x7F → next cycle tx_valid = 0, TCNT = 0, TCMP = 0xFF, data_out = 0x00, and previously written RAM data is intact.
